// File: rtl/sdram_arbiter_pkg.sv
// Shared constants for the SDRAM command arbiter.
// Holds command encodings, arbiter states and the idle bus values.
package sdram_arbiter_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_LOAD_MODE  = 4'b0000;
    localparam logic [3:0] CMD_REFRESH    = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_READ       = 4'b0101;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_NOP        = 4'b0111;

    localparam logic [1:0]  IDLE_BA   = 2'b11;
    localparam logic [12:0] IDLE_ADDR = 13'h1FFF;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } sdram_bus_t;

endpackage

// File: rtl/sdram_arbiter_cmd_mux.sv
// Combinational 4-way command/bank/address mux plus DQ enable,
// selected by the arbiter state.
module sdram_arbiter_cmd_mux
    import sdram_arbiter_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  arb_state_e        state_i,
    input  sdram_bus_t        init_bus_i,
    input  sdram_bus_t        aref_bus_i,
    input  sdram_bus_t        wr_bus_i,
    input  sdram_bus_t        rd_bus_i,
    input  logic              wr_sdram_en_i,
    input  logic [DATA_W-1:0] wr_sdram_data_i,
    output sdram_bus_t        bus_o,
    output logic [DATA_W-1:0] dq_o,
    output logic              dq_oe_o
);

    always_comb begin
        bus_o   = init_bus_i;
        dq_oe_o = 1'b0;
        unique case (state_i)
            ST_INIT:  bus_o = init_bus_i;
            ST_AREF:  bus_o = aref_bus_i;
            ST_WRITE: begin
                bus_o   = wr_bus_i;
                dq_oe_o = wr_sdram_en_i;
            end
            ST_READ:  bus_o = rd_bus_i;
            ST_ARBIT: bus_o = '{cmd: CMD_NOP, ba: IDLE_BA, addr: IDLE_ADDR};
            default:  bus_o = init_bus_i;
        endcase
    end

    assign dq_o = wr_sdram_data_i;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: init hold, then refresh > write > read grants.
// Optional refresh-miss counter with SDRAM_ARB_REF_MISS_CNT_EN.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    input  logic              init_end_i,
    input  logic [3:0]        init_cmd_i,
    input  logic [1:0]        init_ba_i,
    input  logic [12:0]       init_addr_i,
    input  logic              aref_req_i,
    input  logic              aref_end_i,
    input  logic [3:0]        aref_cmd_i,
    input  logic [1:0]        aref_ba_i,
    input  logic [12:0]       aref_addr_i,
    output logic              aref_en_o,
    input  logic              wr_req_i,
    input  logic              wr_end_i,
    input  logic [3:0]        wr_cmd_i,
    input  logic [1:0]        wr_ba_i,
    input  logic [12:0]       wr_addr_i,
    input  logic              wr_sdram_en_i,
    input  logic [DATA_W-1:0] wr_sdram_data_i,
    output logic              wr_en_o,
    input  logic              rd_req_i,
    input  logic              rd_end_i,
    input  logic [3:0]        rd_cmd_i,
    input  logic [1:0]        rd_ba_i,
    input  logic [12:0]       rd_addr_i,
    output logic              rd_en_o,
    output logic              sdram_cke_o,
    output logic              sdram_cs_n_o,
    output logic              sdram_ras_n_o,
    output logic              sdram_cas_n_o,
    output logic              sdram_we_n_o,
    output logic [1:0]        sdram_ba_o,
    output logic [12:0]       sdram_addr_o,
    output logic [DATA_W-1:0] sdram_dq_o,
    output logic              sdram_dq_oe_o
`ifdef SDRAM_ARB_REF_MISS_CNT_EN
    ,
    output logic [7:0]        ref_miss_cnt_o
`endif
);

    arb_state_e state_q;
    logic       pend_q;
    logic       pend_w;
    logic       take_w;
    logic       pend_d;
    logic       cke_q;
    logic       aref_en_q;
    logic       wr_en_q;
    logic       rd_en_q;
    sdram_bus_t bus_w;

    // A request pulse seen in ARBIT is granted in the very next cycle.
    assign pend_w = pend_q | aref_req_i;
    assign take_w = (state_q == ST_ARBIT) && pend_w;
    assign pend_d = take_w ? (pend_q & aref_req_i) : pend_w;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_INIT;
            pend_q    <= 1'b0;
            cke_q     <= 1'b0;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            cke_q  <= 1'b1;
            pend_q <= pend_d;
            unique case (state_q)
                ST_INIT: begin
                    if (init_end_i) state_q <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (pend_w) begin
                        state_q   <= ST_AREF;
                        aref_en_q <= 1'b1;
                    end else if (wr_req_i) begin
                        state_q <= ST_WRITE;
                        wr_en_q <= 1'b1;
                    end else if (rd_req_i) begin
                        state_q <= ST_READ;
                        rd_en_q <= 1'b1;
                    end
                end
                ST_AREF: begin
                    if (aref_end_i) begin
                        state_q   <= ST_ARBIT;
                        aref_en_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_end_i) begin
                        state_q <= ST_ARBIT;
                        wr_en_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (rd_end_i) begin
                        state_q <= ST_ARBIT;
                        rd_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_INIT;
                    aref_en_q <= 1'b0;
                    wr_en_q   <= 1'b0;
                    rd_en_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SDRAM_ARB_REF_MISS_CNT_EN
    logic [7:0] miss_q;
    logic [7:0] miss_d;

    always_comb begin
        miss_d = miss_q;
        if (aref_req_i && pend_q && (miss_q != 8'hFF)) miss_d = miss_q + 8'd1;
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) miss_q <= 8'd0;
        else          miss_q <= miss_d;
    end

    assign ref_miss_cnt_o = miss_q;
`endif

    sdram_arbiter_cmd_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .state_i         (state_q),
        .init_bus_i      ('{cmd: init_cmd_i, ba: init_ba_i, addr: init_addr_i}),
        .aref_bus_i      ('{cmd: aref_cmd_i, ba: aref_ba_i, addr: aref_addr_i}),
        .wr_bus_i        ('{cmd: wr_cmd_i, ba: wr_ba_i, addr: wr_addr_i}),
        .rd_bus_i        ('{cmd: rd_cmd_i, ba: rd_ba_i, addr: rd_addr_i}),
        .wr_sdram_en_i   (wr_sdram_en_i),
        .wr_sdram_data_i (wr_sdram_data_i),
        .bus_o           (bus_w),
        .dq_o            (sdram_dq_o),
        .dq_oe_o         (sdram_dq_oe_o)
    );

    assign {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} = bus_w.cmd;
    assign sdram_ba_o   = bus_w.ba;
    assign sdram_addr_o = bus_w.addr;
    assign sdram_cke_o  = cke_q;
    assign aref_en_o    = aref_en_q;
    assign wr_en_o      = wr_en_q;
    assign rd_en_o      = rd_en_q;

endmodule
